// File: rtl/score4_pkg.sv
// score4_pkg: board geometry, FSM states, result encoding and cell indexing.
package score4_pkg;
  localparam int ROWS = 6;
  localparam int COLS = 7;
  localparam int CELLS = ROWS * COLS;
  typedef enum logic [2:0] {IDLE, FIND, PLACE, CHECK, WIN, NEXT, CLEAR} state_t;
  localparam logic [1:0] W_NONE = 2'b00;
  localparam logic [1:0] W_RED = 2'b01;
  localparam logic [1:0] W_YELLOW = 2'b10;
  localparam logic [1:0] W_DRAW = 2'b11;
  function automatic logic [5:0] cell_idx(input logic [3:0] r, input logic [3:0] c);
    logic [5:0] rr, cc;
    rr = {2'b00, r};
    cc = {2'b00, c};
    return rr * 6'd7 + cc;
  endfunction
endpackage

// File: rtl/score4_frame_tick.sv
// score4_frame_tick: one tick per frame at the start of vertical blanking, plus per-tick button press detection.
module score4_frame_tick #(
  parameter int VBLANK_ROW = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] rows_i,
  input  logic [9:0] columns_i,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_drop,
  output logic       tick,
  output logic       press_left,
  output logic       press_right,
  output logic       press_drop
);
  logic at_vb, at_vb_q;
  logic [2:0] hist;
  // columns_i holds each value for two cycles, so only the rising edge of the match counts
  assign at_vb = rows_i == 10'(VBLANK_ROW) && columns_i == 10'd0;
  assign tick = at_vb & ~at_vb_q;
  assign press_left = tick & btn_left & ~hist[0];
  assign press_right = tick & btn_right & ~hist[1];
  assign press_drop = tick & btn_drop & ~hist[2];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      at_vb_q <= 1'b0;
      hist <= 3'b000;
    end else begin
      at_vb_q <= at_vb;
      if (tick) hist <= {btn_drop, btn_right, btn_left};
    end
endmodule

// File: rtl/score4_game_ctrl.sv
// score4_game_ctrl: frame-synchronous Score 4 sequencer; drops pieces, checks four-in-a-row, publishes state in vblank.
module score4_game_ctrl
  import score4_pkg::*;
#(
  parameter int VBLANK_ROW = 480,
  parameter int CURSOR_INIT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [9:0]       rows_i,
  input  logic [9:0]       columns_i,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_drop,
  output logic [2:0]       cursor_col,
  output logic             player,
  output logic [CELLS-1:0] board_red,
  output logic [CELLS-1:0] board_yellow,
  output logic [1:0]       winner,
  output logic             game_over
);
  state_t state, state_n;
  logic tick, p_l, p_r, p_d;
  logic [3:0] scan_r;
  logic signed [3:0] lr, lc, pr, pc, cr, cc, dr, dc;
  logic [1:0] dir, k;
  logic neg, hit, end_side, empty;
  logic [2:0] run, run_n;
  logic [5:0] count, idx_find;
  logic [CELLS-1:0] own;

  score4_frame_tick #(.VBLANK_ROW(VBLANK_ROW)) u_tick (
    .clk(clk), .rst(rst), .rows_i(rows_i), .columns_i(columns_i),
    .btn_left(btn_left), .btn_right(btn_right), .btn_drop(btn_drop),
    .tick(tick), .press_left(p_l), .press_right(p_r), .press_drop(p_d)
  );

  assign game_over = winner != W_NONE;

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (tick) state_n = p_d ? (game_over ? CLEAR : FIND) : IDLE;
      FIND: state_n = empty ? PLACE : (scan_r == 4'd5 ? IDLE : FIND);
      PLACE: state_n = CHECK;
      CHECK: state_n = run_n >= 3'd4 ? WIN : (end_side && neg && dir == 2'd3 ? NEXT : CHECK);
      default: state_n = IDLE;
    endcase
  end

  // walk one cell from (pr,pc) along the current direction, negated on the second side
  always_comb begin
    dr = dir == 2'd0 ? 4'sd0 : 4'sd1;
    dc = dir == 2'd1 ? 4'sd0 : (dir == 2'd3 ? -4'sd1 : 4'sd1);
    cr = neg ? pr - dr : pr + dr;
    cc = neg ? pc - dc : pc + dc;
    own = player ? board_yellow : board_red;
    hit = cr >= 4'sd0 && cr < 4'(ROWS) && cc >= 4'sd0 && cc < 4'(COLS) && own[cell_idx(cr, cc)];
    run_n = run + {2'b00, hit};
    end_side = !hit || k == 2'd2;
    idx_find = cell_idx(scan_r, {1'b0, cursor_col});
    empty = !(board_red[idx_find] | board_yellow[idx_find]);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cursor_col <= 3'(CURSOR_INIT);
      player <= 1'b0;
      board_red <= '0;
      board_yellow <= '0;
      winner <= W_NONE;
      scan_r <= '0;
      lr <= '0;
      lc <= '0;
      pr <= '0;
      pc <= '0;
      dir <= '0;
      k <= '0;
      neg <= 1'b0;
      run <= '0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          scan_r <= '0;
          if (!game_over && !p_d && (p_l ^ p_r))
            cursor_col <= p_l ? cursor_col - {2'b00, cursor_col != 3'd0}
                              : cursor_col + {2'b00, cursor_col != 3'd6};
        end
        FIND: if (!empty) scan_r <= scan_r + 4'd1;
        PLACE: begin
          if (player) board_yellow[idx_find] <= 1'b1;
          else board_red[idx_find] <= 1'b1;
          lr <= scan_r;
          lc <= {1'b0, cursor_col};
          pr <= scan_r;
          pc <= {1'b0, cursor_col};
          dir <= '0;
          k <= '0;
          neg <= 1'b0;
          run <= 3'd1;
          count <= count + 6'd1;
        end
        CHECK: begin
          run <= run_n;
          if (end_side) begin
            pr <= lr;
            pc <= lc;
            k <= '0;
            neg <= ~neg;
            if (neg) begin
              dir <= dir + 2'd1;
              run <= 3'd1;
            end
          end else begin
            pr <= cr;
            pc <= cc;
            k <= k + 2'd1;
          end
        end
        WIN: winner <= player ? W_YELLOW : W_RED;
        NEXT: if (count == 6'(CELLS)) winner <= W_DRAW;
              else player <= ~player;
        CLEAR: begin
          board_red <= '0;
          board_yellow <= '0;
          count <= '0;
          player <= 1'b0;
          cursor_col <= 3'(CURSOR_INIT);
          winner <= W_NONE;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_score4_game_ctrl.sv
// tb_score4_game_ctrl: frame-level scoreboard against a brute-force Connect Four reference model.
module tb_score4_game_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [9:0] rows_i, columns_i;
  logic btn_left, btn_right, btn_drop;
  logic [2:0] cursor_col;
  logic player, game_over;
  logic [41:0] board_red, board_yellow;
  logic [1:0] winner;

  int passed = 0;
  int total = 0;
  logic [41:0] m_red, m_yel;
  logic [2:0] m_cur, m_hist;
  logic m_pl;
  logic [1:0] m_win;
  int m_cnt;
  logic [90:0] sbq[$];
  logic [90:0] got_q[$];

  score4_game_ctrl dut (
    .clk(clk), .rst(rst), .rows_i(rows_i), .columns_i(columns_i),
    .btn_left(btn_left), .btn_right(btn_right), .btn_drop(btn_drop),
    .cursor_col(cursor_col), .player(player), .board_red(board_red),
    .board_yellow(board_yellow), .winner(winner), .game_over(game_over)
  );

  always #5 clk = ~clk;

  function automatic logic [90:0] dut_vec();
    return {cursor_col, player, board_red, board_yellow, winner, game_over};
  endfunction

  function automatic logic [90:0] model_vec();
    return {m_cur, m_pl, m_red, m_yel, m_win, m_win != 2'b00};
  endfunction

  // any four owned cells in a straight line anywhere on the board
  function automatic bit has4(input logic [41:0] b);
    int dr, dc, n, rr, cc;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++)
        for (int d = 0; d < 4; d++) begin
          dr = d == 0 ? 0 : 1;
          dc = d == 1 ? 0 : (d == 3 ? -1 : 1);
          n = 0;
          for (int s = 0; s < 4; s++) begin
            rr = r + s * dr;
            cc = c + s * dc;
            if (rr >= 0 && rr < 6 && cc >= 0 && cc < 7) if (b[rr * 7 + cc]) n++;
          end
          if (n == 4) return 1'b1;
        end
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_red = '0; m_yel = '0; m_cur = 3'd3; m_pl = 1'b0; m_win = 2'b00; m_hist = 3'b000; m_cnt = 0;
  endtask

  task automatic model_tick(input logic l, input logic r, input logic d);
    logic pl, pr, pd;
    int row;
    pl = l & ~m_hist[0];
    pr = r & ~m_hist[1];
    pd = d & ~m_hist[2];
    m_hist = {d, r, l};
    if (m_win != 2'b00) begin
      if (pd) begin
        m_red = '0; m_yel = '0; m_cnt = 0; m_pl = 1'b0; m_cur = 3'd3; m_win = 2'b00;
      end
    end else if (pd) begin
      row = -1;
      for (int i = 5; i >= 0; i--) if (!m_red[i * 7 + int'(m_cur)] && !m_yel[i * 7 + int'(m_cur)]) row = i;
      if (row >= 0) begin
        if (m_pl) m_yel[row * 7 + int'(m_cur)] = 1'b1;
        else m_red[row * 7 + int'(m_cur)] = 1'b1;
        m_cnt++;
        if (has4(m_pl ? m_yel : m_red)) m_win = m_pl ? 2'b10 : 2'b01;
        else if (m_cnt == 42) m_win = 2'b11;
        else m_pl = ~m_pl;
      end
    end else if (pl ^ pr) begin
      m_cur = pl ? (m_cur == 3'd0 ? 3'd0 : m_cur - 3'd1) : (m_cur == 3'd6 ? 3'd6 : m_cur + 3'd1);
    end
  endtask

  // compressed frame: last visible pixel, vblank start (tick), then settle well past the 33-cycle worst case
  task automatic frame(input logic l, input logic r, input logic d);
    btn_left = l; btn_right = r; btn_drop = d;
    model_tick(l, r, d);
    sbq.push_back(model_vec());
    rows_i = 10'd479; columns_i = 10'd799;
    repeat (2) @(negedge clk);
    rows_i = 10'd480; columns_i = 10'd0;
    repeat (2) @(negedge clk);
    columns_i = 10'd1;
    repeat (50) @(negedge clk);
    rows_i = 10'd500;
    repeat (2) @(negedge clk);
    got_q.push_back(dut_vec());
  endtask

  task automatic press(input logic l, input logic r, input logic d);
    frame(l, r, d);
    frame(1'b0, 1'b0, 1'b0);
  endtask

  task automatic goto(input int col);
    while (int'(m_cur) != col) press(int'(m_cur) > col, int'(m_cur) < col, 1'b0);
  endtask

  task automatic do_reset();
    btn_left = 1'b0; btn_right = 1'b0; btn_drop = 1'b0;
    rows_i = 10'd100; columns_i = 10'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    model_reset();
    sbq.delete();
    got_q.delete();
  endtask

  task automatic test_reset();
    logic [90:0] e, g;
    do_reset();
    total++;
    if (dut_vec() !== {3'd3, 88'd0}) $display("FAIL reset_values got %h exp %h", dut_vec(), {3'd3, 88'd0});
    else passed++;
    frame(1'b0, 1'b0, 1'b0);
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); g = got_q.pop_front(); total++;
      if (g !== e) $display("FAIL idle_frame got %h exp %h", g, e); else passed++;
    end
  endtask

  task automatic test_hold_drop();
    logic [90:0] e, g;
    int rvs[5] = '{0, 120, 240, 360, 479};
    do_reset();
    repeat (3) frame(1'b0, 1'b0, 1'b1);
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); g = got_q.pop_front(); total++;
      if (g !== e) $display("FAIL hold_drop got %h exp %h", g, e); else passed++;
    end
    foreach (rvs[i]) begin
      rows_i = 10'(rvs[i]); columns_i = 10'd0;
      repeat (3) @(negedge clk);
      columns_i = 10'd400;
      repeat (3) @(negedge clk);
      total++;
      if (dut_vec() !== model_vec()) $display("FAIL visible_stable row %0d got %h exp %h", rvs[i], dut_vec(), model_vec());
      else passed++;
    end
    total++;
    if (board_red !== 42'h8 || board_yellow !== 42'h0 || player !== 1'b1)
      $display("FAIL single_drop got red=%h yel=%h pl=%b exp red=8 yel=0 pl=1", board_red, board_yellow, player);
    else passed++;
  endtask

  task automatic test_col_full();
    logic [90:0] e, g;
    logic [41:0] occ;
    do_reset();
    goto(0);
    repeat (7) press(1'b0, 1'b0, 1'b1);
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); g = got_q.pop_front(); total++;
      if (g !== e) $display("FAIL col_full got %h exp %h", g, e); else passed++;
    end
    occ = '0;
    for (int i = 0; i < 6; i++) occ[i * 7] = 1'b1;
    total++;
    if ((board_red | board_yellow) !== occ || player !== 1'b0)
      $display("FAIL col_full_final got occ=%h pl=%b exp occ=%h pl=0", board_red | board_yellow, player, occ);
    else passed++;
  endtask

  task automatic test_red_win();
    logic [90:0] e, g;
    int cols[7] = '{0, 0, 1, 0, 2, 0, 3};
    do_reset();
    foreach (cols[i]) begin
      goto(cols[i]);
      press(1'b0, 1'b0, 1'b1);
    end
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); g = got_q.pop_front(); total++;
      if (g !== e) $display("FAIL red_win got %h exp %h", g, e); else passed++;
    end
    total++;
    if (winner !== 2'b01 || game_over !== 1'b1 || cursor_col !== 3'd3)
      $display("FAIL red_win_final got w=%b go=%b cur=%0d exp w=01 go=1 cur=3", winner, game_over, cursor_col);
    else passed++;
  endtask

  task automatic test_yellow_win();
    logic [90:0] e, g;
    int cols[12] = '{3, 4, 2, 3, 1, 1, 1, 2, 6, 1, 6, 2};
    do_reset();
    foreach (cols[i]) begin
      goto(cols[i]);
      press(1'b0, 1'b0, 1'b1);
    end
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); g = got_q.pop_front(); total++;
      if (g !== e) $display("FAIL yellow_win got %h exp %h", g, e); else passed++;
    end
    total++;
    if (winner !== 2'b10 || game_over !== 1'b1)
      $display("FAIL yellow_antidiag got w=%b go=%b exp w=10 go=1", winner, game_over);
    else passed++;
    press(1'b0, 1'b0, 1'b1);
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); g = got_q.pop_front(); total++;
      if (g !== e) $display("FAIL restart got %h exp %h", g, e); else passed++;
    end
    total++;
    if (dut_vec() !== {3'd3, 88'd0}) $display("FAIL clear_values got %h exp %h", dut_vec(), {3'd3, 88'd0});
    else passed++;
  endtask

  task automatic test_cursor();
    logic [90:0] e, g;
    do_reset();
    goto(0);
    press(1'b1, 1'b1, 1'b0);
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); g = got_q.pop_front(); total++;
      if (g !== e) $display("FAIL cursor_left got %h exp %h", g, e); else passed++;
    end
    total++;
    if (cursor_col !== 3'd0) $display("FAIL left_right_both got %0d exp 0", cursor_col); else passed++;
    repeat (10) press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b1);
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); g = got_q.pop_front(); total++;
      if (g !== e) $display("FAIL cursor_right got %h exp %h", g, e); else passed++;
    end
    total++;
    if (cursor_col !== 3'd6 || board_red[6] !== 1'b1)
      $display("FAIL saturate_drop_priority got cur=%0d red6=%b exp cur=6 red6=1", cursor_col, board_red[6]);
    else passed++;
  endtask

  task automatic test_rst_check();
    logic [90:0] e, g;
    do_reset();
    btn_drop = 1'b1;
    rows_i = 10'd479; columns_i = 10'd799;
    @(negedge clk);
    rows_i = 10'd480; columns_i = 10'd0;
    repeat (5) @(negedge clk);
    total++;
    if (board_red[3] !== 1'b1) $display("FAIL move_in_flight got red3=%b exp 1", board_red[3]); else passed++;
    rows_i = 10'd100; btn_drop = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (dut_vec() !== {3'd3, 88'd0}) $display("FAIL rst_in_check got %h exp %h", dut_vec(), {3'd3, 88'd0});
    else passed++;
    rst = 1'b0;
    @(negedge clk);
    model_reset();
    frame(1'b0, 1'b0, 1'b0);
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); g = got_q.pop_front(); total++;
      if (g !== e) $display("FAIL after_rst got %h exp %h", g, e); else passed++;
    end
  endtask

  initial begin
    rst = 1'b1;
    rows_i = 10'd100; columns_i = 10'd0;
    btn_left = 1'b0; btn_right = 1'b0; btn_drop = 1'b0;
    test_reset();
    test_hold_drop();
    test_col_full();
    test_red_win();
    test_yellow_win();
    test_cursor();
    test_rst_check();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
